mac_accumulator: RTL and testbench

Unsigned accumulate stage directly downstream of the 32x32 bitwise multiplier. It consumes the multiplier's registered 64-bit products as a valid/ready stream and sums them over frames delimited by `in_last`. For each frame it emits one wide sum, a beat count and an overflow flag through a valid/ready output handshake. Together with the multiplier it forms the dot-product path.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_sat_add.sv | 32 +++
 rtl/mac_accumulator.sv | 104 ++++++++++
 tb/tb_mac_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the mac_accumulator dot-product stage.
// Optional build macro MAC_ACC_SAT_EN selects saturating accumulation.
package mac_pkg;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } mac_state_t;

    localparam int MAC_PROD_W = 64;
    localparam int MAC_ACC_W  = 72;
    localparam int MAC_CNT_W  = 16;

    localparam logic [MAC_ACC_W-1:0] MAC_ACC_ONES = {MAC_ACC_W{1'b1}};

endpackage

// File: rtl/mac_sat_add.sv
// ACC_W-bit unsigned adder with carry-out; with MAC_ACC_SAT_EN defined the
// sum clamps to all-ones whenever the add carries out.
import mac_pkg::*;

module mac_sat_add #(
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_full;

    // Full-width add; once clamped, any further non-zero add carries again,
    // so the clamp holds for the rest of the frame without extra state.
    always_comb begin
        w_full  = {1'b0, i_a} + {1'b0, i_b};
        o_carry = w_full[ACC_W];
`ifdef MAC_ACC_SAT_EN
        if (w_full[ACC_W]) begin
            o_sum = {ACC_W{1'b1}};
        end else begin
            o_sum = w_full[ACC_W-1:0];
        end
`else
        o_sum = w_full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator behind the 32x32 multiplier: sums products until in_last,
// then presents sum/count/overflow on a valid/ready port. Macro: MAC_ACC_SAT_EN.
import mac_pkg::*;

module mac_accumulator #(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int CNT_W  = MAC_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [PROD_W-1:0] i_in_prod,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_out_acc,
    output logic [CNT_W-1:0]  o_out_count,
    output logic              o_out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    mac_state_t       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_accept;

    assign w_prod_ext = ACC_W'(i_in_prod);
    assign w_accept   = i_in_valid & r_in_ready;

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a     (r_acc),
        .i_b     (w_prod_ext),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Frame FSM: in_ready is held as a register so it never depends on out_ready.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_ACC;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + CNT_ONE;
                        end
                        if (i_in_last) begin
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_out_ready) begin
                        r_state     <= ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_ovf       <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_acc   = r_acc;
    assign o_out_count = r_count;
    assign o_out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a default-width instance and a 64-bit/2-bit-count
// instance share stimulus and are checked against a frame-sum reference model.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [63:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [71:0] a_out_acc;
    logic [15:0] a_out_count;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [63:0] b_out_acc;
    logic [1:0]  b_out_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic        seen_edge = 1'b0;

    logic [127:0] m_sum = 128'd0;
    int           m_n = 0;
    logic         m_hold = 1'b0;
    logic         m_rdy = 1'b0;

    always #5 clk = ~clk;

    mac_accumulator u_dut_a (
        .clk         (clk),
        .rstn        (rstn),
        .i_in_valid  (in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_prod   (in_prod),
        .i_in_last   (in_last),
        .o_out_valid (a_out_valid),
        .i_out_ready (out_ready),
        .o_out_acc   (a_out_acc),
        .o_out_count (a_out_count),
        .o_out_ovf   (a_out_ovf)
    );

    mac_accumulator #(
        .PROD_W (64),
        .ACC_W  (64),
        .CNT_W  (2)
    ) u_dut_b (
        .clk         (clk),
        .rstn        (rstn),
        .i_in_valid  (in_valid),
        .o_in_ready  (b_in_ready),
        .i_in_prod   (in_prod),
        .i_in_last   (in_last),
        .o_out_valid (b_out_valid),
        .i_out_ready (out_ready),
        .o_out_acc   (b_out_acc),
        .o_out_count (b_out_count),
        .o_out_ovf   (b_out_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] acc_max(input int w);
        return (128'd1 << w) - 128'd1;
    endfunction

    function automatic logic [127:0] exp_acc(input logic [127:0] s, input int w);
`ifdef MAC_ACC_SAT_EN
        return (s > acc_max(w)) ? acc_max(w) : s;
`else
        return s & acc_max(w);
`endif
    endfunction

    function automatic logic [127:0] exp_cnt(input int n, input int c);
        logic [127:0] cm;
        cm = acc_max(c);
        return (128'(n) > cm) ? cm : 128'(n);
    endfunction

    always @(posedge clk) seen_edge <= 1'b1;

    // Reference model: compare outputs, then predict the effect of the next edge.
    always @(negedge clk) begin
        if (seen_edge) begin
            chk("a_in_ready",  a_in_ready,  m_rdy);
            chk("b_in_ready",  b_in_ready,  m_rdy);
            chk("a_out_valid", a_out_valid, m_hold);
            chk("b_out_valid", b_out_valid, m_hold);
            chk("a_out_acc",   a_out_acc,   exp_acc(m_sum, 72));
            chk("b_out_acc",   b_out_acc,   exp_acc(m_sum, 64));
            chk("a_out_count", a_out_count, exp_cnt(m_n, 16));
            chk("b_out_count", b_out_count, exp_cnt(m_n, 2));
            chk("a_out_ovf",   a_out_ovf,   m_sum > acc_max(72));
            chk("b_out_ovf",   b_out_ovf,   m_sum > acc_max(64));
        end
        if (!rstn) begin
            m_sum = 128'd0; m_n = 0; m_hold = 1'b0; m_rdy = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_sum = 128'd0; m_n = 0; m_hold = 1'b0; m_rdy = 1'b1;
            end
        end else begin
            if (in_valid && m_rdy) begin
                m_sum = m_sum + {64'd0, in_prod};
                m_n++;
                if (in_last) m_hold = 1'b1;
            end
            m_rdy = !m_hold;
        end
    end

    task automatic send_beat(input logic [63:0] p, input logic l);
        int t;
        in_valid = 1'b1; in_prod = p; in_last = l; t = 0;
        @(negedge clk);
        while (!a_in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("hs_timeout", a_in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc_now;
        rstn = 1'b0; in_valid = 1'b1; in_prod = 64'd6; in_last = 1'b0; out_ready = 1'b1;
        idle(3);
        rstn = 1'b1;

        send_beat(64'd6, 1'b0);
        send_beat(64'd20, 1'b0);
        send_beat(64'd35, 1'b1);
        send_beat(64'd4, 1'b1);
        idle(2);

        out_ready = 1'b0;
        send_beat(64'd100, 1'b1);
        idle(5);
        out_ready = 1'b1;
        idle(2);

        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_beat(64'd2, 1'b1);
        idle(2);

        send_beat(64'd5, 1'b0);
        send_beat(64'd7, 1'b0);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        send_beat(64'd9, 1'b1);
        idle(2);

        for (int i = 0; i < 5; i++) send_beat(64'd1, (i == 4) ? 1'b1 : 1'b0);
        idle(2);

        for (int c = 0; c < 600; c++) begin
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 2))
                    0:       in_prod = 64'($urandom_range(0, 100));
                    1:       in_prod = {$urandom(), $urandom()};
                    default: in_prod = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                endcase
                in_last  = ($urandom_range(0, 5) == 0);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rstn      = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            acc_now = in_valid && a_in_ready && rstn;
            @(posedge clk); #1;
            if (acc_now) in_valid = 1'b0;
        end

        in_valid = 1'b0; rstn = 1'b1; out_ready = 1'b1;
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
